// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared store-size encodings, store FSM states and request legality check
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WRITE   = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // True for any request that must fault without touching memory.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - big-endian replacement of a byte or halfword lane inside a 32-bit word
module byte_lane_merge
  import mips_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    case (size)
      // Lowest byte address maps to the most significant lane.
      SZ_BYTE: begin
        case (addr_lo)
          2'b00:   merged_word[31:24] = new_data[7:0];
          2'b01:   merged_word[23:16] = new_data[7:0];
          2'b10:   merged_word[15:8]  = new_data[7:0];
          default: merged_word[7:0]   = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged_word[15:0]  = new_data[15:0];
        else            merged_word[31:16] = new_data[15:0];
      end
      SZ_WORD: merged_word = new_data;
      default: merged_word = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge.sv
// rtl/store_merge.sv - sub-word store via read-modify-write with read timeout and fault reporting
module store_merge
  import mips_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int RD_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              done,
  output logic              fault
);

  localparam int CNT_W = $clog2(RD_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT_MAX - 1);

  state_t            state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_size;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       merged;

  byte_lane_merge u_merge (
    .old_word    (mem_rdata),
    .new_data    (r_data),
    .addr_lo     (r_addr[1:0]),
    .size        (r_size),
    .merged_word (merged)
  );

  assign req_ready = (state == IDLE) && !rst;

  // All memory-side outputs are registered and default to zero so strobes are single-cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_size    <= SZ_BYTE;
      wait_cnt  <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            r_data <= req_data;
            r_size <= req_size;
            if (is_bad_req(req_size, req_addr[1:0])) begin
              state <= FAULT;
              fault <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state     <= WRITE;
              mem_wr_en <= 1'b1;
              done      <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_data;
            end else begin
              state     <= RD_REQ;
              mem_rd_en <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD_REQ: begin
          state    <= RD_WAIT;
          wait_cnt <= '0;
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            state     <= WRITE;
            mem_wr_en <= 1'b1;
            done      <= 1'b1;
            mem_addr  <= {r_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= merged;
          end else if (wait_cnt == CNT_LAST) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WRITE:   state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter RD_WAIT_MAX, default 15, maximum cycles waited for mem_rvalid before abort.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  store request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_addr  input  ADDR_W  byte address of store.
REQ-008 req_data  input  32  store data; only the low byte (SB) or low half (SH) is used.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 mem_rd_en  output  1  one-cycle word read strobe.
REQ-011 mem_wr_en  output  1  one-cycle word write strobe.
REQ-012 mem_addr  output  ADDR_W  word-aligned address, bits [1:0] always 00.
REQ-013 mem_wdata  output  32  full word to write.
REQ-014 mem_rdata  input  32  read word, valid when mem_rvalid=1.
REQ-015 mem_rvalid  input  1  read data valid, latency >= 1 cycle after mem_rd_en.
REQ-016 done  output  1  one-cycle pulse: store committed.
REQ-017 fault  output  1  one-cycle pulse: misaligned/illegal request or read timeout.

Function
REQ-018 The block SHALL implement states IDLE, RD_REQ, RD_WAIT, WRITE, FAULT.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid=1 and req_ready=1, and all request fields are registered at acceptance.
REQ-020 Byte lanes SHALL be big-endian: addr[1:0]=00 selects bits [31:24], 11 selects [7:0]; halfword addr[1]=0 selects [31:16].
REQ-021 Misaligned (SH with addr[0]=1, SW with addr[1:0]!=00) or size 11 SHALL go IDLE->FAULT, pulse fault one cycle after acceptance, issue no memory strobe, then return to IDLE.
REQ-022 SW SHALL go IDLE->WRITE: mem_wr_en=1, mem_wdata=req_data, done=1 in the cycle after acceptance, then IDLE.
REQ-023 SB/SH SHALL go IDLE->RD_REQ (mem_rd_en=1 for exactly one cycle, the cycle after acceptance) ->RD_WAIT.
REQ-024 In RD_WAIT, on mem_rvalid=1 the block SHALL register mem_rdata with the selected lane replaced by req_data[7:0] or req_data[15:0], other lanes unchanged, and go to WRITE.
REQ-025 WRITE SHALL assert mem_wr_en and done together for exactly one cycle, cycle after mem_rvalid.
REQ-026 If RD_WAIT lasts RD_WAIT_MAX cycles without mem_rvalid, the block SHALL go to FAULT, issue no write.
REQ-027 mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-028 mem_addr SHALL equal {req_addr[ADDR_W-1:2],2'b00} while rd/wr strobes are high; mem_wdata SHALL be 0 when mem_wr_en=0.
REQ-029 At most one request SHALL be in flight; back-to-back requests accepted no earlier than the cycle after done/fault.

Reset
REQ-030 rst=1 SHALL force IDLE; req_ready=1, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, done=0, fault=0, timeout counter=0 on the next edge.
REQ-031 Reset in RD_REQ/RD_WAIT/WRITE SHALL abandon the request; no write issues afterwards, and a late mem_rvalid SHALL be ignored.
REQ-032 req_ready SHALL be 0 during cycles where rst=1.

Structure
REQ-033 Size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the state enum SHALL live in shared package mips_pkg.
REQ-034 Lane merge SHALL be a combinational sub-module byte_lane_merge(old_word, new_data, addr_lo, size -> merged_word); FSM and timeout counter stay in store_merge.

Verification
REQ-035 SW addr 0x100, data 0xDEADBEEF -> next cycle mem_wr_en=1, mem_addr 0x100, mem_wdata 0xDEADBEEF, done=1; no mem_rd_en.
REQ-036 SB addr 0x203, data 0xFFFFFF5A, mem_rdata 0x11223344 after 3-cycle latency -> mem_wdata 0x1122335A, mem_addr 0x200, done one cycle after mem_rvalid.
REQ-037 SH addr 0x202, data 0x0000ABCD, mem_rdata 0x11223344 -> mem_wdata 0x1122ABCD; SH addr 0x200 -> 0xABCD3344.
REQ-038 SH addr 0x201 and SW addr 0x102 and size 11 -> fault pulse each, zero strobes.
REQ-039 SB, mem_rvalid withheld 15 cycles -> fault, no mem_wr_en; later mem_rvalid ignored, req_ready=1.
REQ-040 rst asserted in RD_WAIT, mem_rvalid two cycles later -> no mem_wr_en, no done, all outputs at reset values.
